// File: rtl/serial_as_ctrl.sv
// Bit-serial add/subtract controller: walks one full adder/subtractor cell
// across WIDTH operand bits LSB-first, then reports result, carry/borrow and overflow.

module full_a_s (
  input  logic in1,
  input  logic in2,
  input  logic mode,
  input  logic carryin,
  output logic sum_diff,
  output logic carry_borr
);
  logic w_m;

  // Inverting in1 for subtract turns the majority carry into a borrow.
  assign w_m        = mode ^ in1;
  assign sum_diff   = in1 ^ in2 ^ carryin;
  assign carry_borr = (w_m & in2) | (w_m & carryin) | (in2 & carryin);
endmodule

module serial_as_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_borr_out,
  output logic             ovf
);
  localparam int CNT_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_result;
  logic               r_mode;
  logic               r_carry;
  logic               r_cbo;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_sum;
  logic               w_cb;
  logic               w_accept;
  logic               w_run;
  logic               w_last;

  function automatic logic ovf_calc(input logic m, input logic sa,
                                    input logic sb, input logic sr);
    if (m)
      return (sa != sb) && (sr != sa);
    else
      return (sa == sb) && (sr != sa);
  endfunction

  assign w_accept = (r_state == IDLE) && start;
  assign w_run    = (r_state == RUN);
  assign w_last   = w_run && (r_cnt == CNT_W'(WIDTH - 1));

  full_a_s u_cell (
    .in1        (r_a_sh[0]),
    .in2        (r_b_sh[0]),
    .mode       (r_mode),
    .carryin    (r_carry),
    .sum_diff   (w_sum),
    .carry_borr (w_cb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand shift registers carry pure data, so they take no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a_sh <= a;
      r_b_sh <= b;
      r_mode <= mode;
    end else if (w_run) begin
      r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cbo    <= 1'b0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_result <= {w_sum, r_result[WIDTH-1:1]};
      r_carry  <= w_cb;
      r_cnt    <= r_cnt + CNT_W'(1);
      // On the last bit the cell is looking at the operand MSBs.
      if (w_last) begin
        r_cbo <= w_cb;
        r_ovf <= ovf_calc(r_mode, r_a_sh[0], r_b_sh[0], w_sum);
      end
    end
  end

  assign busy           = (r_state == RUN);
  assign done           = (r_state == DONE);
  assign result         = r_result;
  assign carry_borr_out = r_cbo;
  assign ovf            = r_ovf;
endmodule

// File: tb/tb_serial_as_ctrl.sv
// Scoreboard bench for serial_as_ctrl: expected results queued at start,
// compared when done pulses.

module tb_serial_as_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_borr_out;
  logic             ovf;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   done_cyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  serial_as_ctrl #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .mode           (mode),
    .a              (a),
    .b              (b),
    .busy           (busy),
    .done           (done),
    .result         (result),
    .carry_borr_out (carry_borr_out),
    .ovf            (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic m);
    logic [WIDTH:0] f;
    exp_t e;
    if (!m) begin
      f   = {1'b0, x} + {1'b0, y};
      e.r = f[WIDTH-1:0];
      e.c = f[WIDTH];
      e.v = (x[WIDTH-1] == y[WIDTH-1]) && (e.r[WIDTH-1] != x[WIDTH-1]);
    end else begin
      e.r = x - y;
      e.c = (x < y);
      e.v = (x[WIDTH-1] != y[WIDTH-1]) && (e.r[WIDTH-1] != x[WIDTH-1]);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (done) begin
      done_cyc.push_back(cyc);
      chk("done_pulse_width", 32'(prev_done), 32'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result", 32'(result), 32'(mon_e.r));
        chk("carry_borr_out", 32'(carry_borr_out), 32'(mon_e.c));
        chk("ovf", 32'(ovf), 32'(mon_e.v));
      end
    end
    prev_done = done;
  end

  // Called at a negedge with the DUT idle; returns cycles from accept edge to done.
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic m, output int lat);
    a = x; b = y; mode = m; start = 1'b1;
    sb_q.push_back(model(x, y, m));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); mode = 1'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int nb;
    int dn;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cbo", 32'(carry_borr_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h5A, 8'h3C, 1'b0, lat);
    chk("latency_add", 32'(lat), 32'd9);
    run_op(8'h10, 8'h20, 1'b1, lat);
    chk("latency_sub", 32'(lat), 32'd9);
    run_op(8'hFF, 8'h01, 1'b0, lat);
    run_op(8'h80, 8'h01, 1'b1, lat);
    run_op(8'h7F, 8'h01, 1'b0, lat);
    run_op(8'h00, 8'h00, 1'b1, lat);
    for (int i = 0; i < 6; i++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), lat);

    // start re-asserted mid-run with different operands must be ignored
    a = 8'h33; b = 8'h11; mode = 1'b0; start = 1'b1;
    sb_q.push_back(model(8'h33, 8'h11, 1'b0));
    @(posedge clk);
    @(negedge clk);
    nb = 0;
    dn = 0;
    for (int i = 1; i <= 12; i++) begin
      if (busy) nb++;
      if (done) dn++;
      if (i == 3) begin
        start = 1'b1; a = 8'hAA; b = 8'h55; mode = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("ignored_start_busy_cycles", 32'(nb), 32'd8);
    chk("ignored_start_done_count", 32'(dn), 32'd1);

    // asynchronous reset in the middle of a run
    a = 8'h12; b = 8'h34; mode = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_cbo", 32'(carry_borr_out), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    repeat (12) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'hC8, 8'h64, 1'b1, lat);
    chk("latency_after_reset", 32'(lat), 32'd9);

    // start held high: one acceptance every WIDTH+2 cycles
    done_cyc.delete();
    a = 8'h01; b = 8'h02; mode = 1'b0; start = 1'b1;
    sb_q.push_back(model(8'h01, 8'h02, 1'b0));
    @(posedge clk);
    @(negedge clk);
    a = 8'h90; b = 8'h90; mode = 1'b0;
    sb_q.push_back(model(8'h90, 8'h90, 1'b0));
    repeat (10) @(posedge clk);
    @(negedge clk);
    a = 8'h05; b = 8'h7F; mode = 1'b1;
    sb_q.push_back(model(8'h05, 8'h7F, 1'b1));
    repeat (10) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("b2b_done_count", 32'(done_cyc.size()), 32'd3);
    if (done_cyc.size() == 3) begin
      chk("b2b_spacing_1", 32'(done_cyc[1] - done_cyc[0]), 32'd10);
      chk("b2b_spacing_2", 32'(done_cyc[2] - done_cyc[1]), 32'd10);
    end
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/serial_as_ctrl.md
# serial_as_ctrl

Bit-serial add/subtract controller that sequences a single 1-bit full adder/subtractor cell (`full_a_s`) over WIDTH clock cycles. It latches two WIDTH-bit operands and a mode on a start handshake, then feeds the cell LSB-first while holding the carry/borrow in a register. It assembles the result and reports carry/borrow-out and signed overflow. This is the area-minimal arithmetic path for slow control datapaths in the design.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse/level; sampled only in IDLE
- mode  in  1  0 = add (a+b), 1 = subtract (a−b); latched with start
- a  in  WIDTH  operand 1 (cell in1); latched with start
- b  in  WIDTH  operand 2 (cell in2); latched with start
- busy  out  1  high while an operation is in progress (RUN state)
- done  out  1  single-cycle pulse: result/flags valid
- result  out  WIDTH  sum or difference; held until next accepted start
- carry_borr_out  out  1  final carry (add) or borrow (sub) from MSB
- ovf  out  1  signed two's-complement overflow

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a clock edge → latch a, b, mode into operand shift registers.
  - Clear carry register to 0 and bit counter to 0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - Cell inputs: in1=a_sh[0], in2=b_sh[0], mode=mode_q, carryin=carry_q.
  - Shift sum_diff into result MSB side (result shifts right), shift a_sh/b_sh right, carry_q ← carry_borr, counter+1.
  - On the edge where counter reaches WIDTH−1 → go to DONE.
- DONE: done=1 for exactly this cycle; next edge → IDLE unconditionally.
- Cell equations (fixed): sum_diff = in1^in2^cin; carry_borr = m&in2 | m&cin | in2&cin, with m = mode^in1.
  - Subtract computes a − b with borrow-in 0; carry_borr_out=1 means a < b unsigned.
- Overflow, latched with the last bit (sa, sb, sr = MSBs of a, b, result):
  - Add: ovf = (sa==sb) & (sr!=sa).
  - Sub: ovf = (sa!=sb) & (sr!=sa).
- start while busy or in DONE: ignored; latched operands unaffected; no queuing.
- Operand inputs may change freely after the accepting edge.
- result, carry_borr_out and ovf are only defined when done=1 and are held stable in IDLE afterwards.
- Reset mid-operation aborts. All state returns to reset values with no done pulse.

## Timing
- Reset values: state=IDLE, busy=0, done=0, result=0, carry_borr_out=0, ovf=0, carry_q=0, counter=0.
- start accepted at edge E0.
- busy=1 in the cycles following E0 through EWIDTH (WIDTH cycles).
- done=1 in the cycle after edge EWIDTH; back to IDLE at EWIDTH+1.
- Minimum start-to-start period: WIDTH+2 cycles. A start held high through DONE is accepted at the first IDLE edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, add 0x5A+0x3C → result=0x96, carry_borr_out=0, ovf=1; done exactly at cycle 9 after start edge.
- Sub 0x10−0x20 → result=0xF0, carry_borr_out=1, ovf=0.
- Add 0xFF+0x01 → result=0x00, carry_borr_out=1, ovf=0. Sub 0x80−0x01 → result=0x7F, carry_borr_out=0, ovf=1.
- Start pulsed again at cycle 3 of RUN with different operands → ignored; first result is unchanged; busy stays high for 8 cycles and done pulses once.
- rst_n low at cycle 4 of RUN → busy/done/result/flags 0 immediately (async); no done. A fresh start after release computes correctly.
- Back-to-back: start held high continuously → operations accepted every 10 cycles (WIDTH+2); each done is 1 cycle wide.
